// File: rtl/cbus_pkg.sv
// Shared Cbus link constants and state encoding, common to the RX deframer and TX framer.
package cbus_pkg;

    localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5 comma / idle
    localparam logic [7:0] K_SOF  = 8'hFB;  // K27.7
    localparam logic [7:0] K_EOF  = 8'hFD;  // K29.7

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        IDLE   = 2'd1,
        FRAME  = 2'd2
    } state_t;

    function automatic logic is_kchar(input logic charisk, input logic [7:0] data,
                                      input logic [7:0] code);
        return charisk && (data == code);
    endfunction

endpackage

// File: rtl/cbus_rx_deframer_if.sv
// Push-only AXI-Stream byte channel: no tready, the slave must accept every beat.
interface cbus_axis_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);

endinterface

// File: rtl/cbus_rx_deframer_sync.sv
// Comma alignment tracker: declares link_up after a run of good commas and
// drops it after a run of bad symbols.
module cbus_rx_sync #(
    parameter int SYNC_COMMAS = 4,
    parameter int BAD_LIMIT   = 4
) (
    input  logic rx_core_clk,
    input  logic rx_reset,
    input  logic sym_valid,
    input  logic sym_bad,
    input  logic sym_is_idle,
    output logic sync_ok,
    output logic lose_sync,
    output logic link_up
);

    localparam int CW = $clog2(SYNC_COMMAS + 1);
    localparam int BW = $clog2(BAD_LIMIT + 1);

    logic [CW-1:0] comma_reg, comma_next;
    logic [BW-1:0] bad_run_reg, bad_run_next;
    logic          link_up_reg, link_up_next;

    always_comb begin
        comma_next   = comma_reg;
        bad_run_next = bad_run_reg;
        link_up_next = link_up_reg;
        sync_ok      = 1'b0;
        lose_sync    = 1'b0;
        if (sym_valid) begin
            // Bad-run saturates so lose_sync pulses only on the symbol that reaches the limit.
            if (sym_bad) begin
                if (bad_run_reg != BW'(BAD_LIMIT)) begin
                    bad_run_next = bad_run_reg + 1'b1;
                end
                if (bad_run_reg == BW'(BAD_LIMIT - 1)) begin
                    lose_sync = 1'b1;
                end
            end else begin
                bad_run_next = '0;
            end

            if (lose_sync) begin
                link_up_next = 1'b0;
                comma_next   = '0;
            end else if (!link_up_reg) begin
                if (sym_is_idle && !sym_bad) begin
                    if (comma_reg == CW'(SYNC_COMMAS - 1)) begin
                        sync_ok      = 1'b1;
                        link_up_next = 1'b1;
                        comma_next   = '0;
                    end else begin
                        comma_next = comma_reg + 1'b1;
                    end
                end else begin
                    comma_next = '0;
                end
            end
        end
    end

    always_ff @(posedge rx_core_clk or posedge rx_reset) begin
        if (rx_reset) begin
            comma_reg   <= '0;
            bad_run_reg <= '0;
            link_up_reg <= 1'b0;
        end else begin
            comma_reg   <= comma_next;
            bad_run_reg <= bad_run_next;
            link_up_reg <= link_up_next;
        end
    end

    assign link_up = link_up_reg;

endmodule

// File: rtl/cbus_rx_deframer.sv
// Cbus RX deframer: strips SOF/EOF from decoded PCS symbols and streams payload
// bytes, holding one byte back so the final byte can carry tlast/tuser.
module cbus_rx_deframer
    import cbus_pkg::*;
#(
    parameter int SYNC_COMMAS = 4,
    parameter int BAD_LIMIT   = 4,
    parameter int MAX_LEN     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             rx_core_clk,
    input  logic             rx_reset,
    input  logic [7:0]       pcs_rxdata,
    input  logic             pcs_rxcharisk,
    input  logic             pcs_rxdisperr,
    input  logic             pcs_rxnotintable,
    input  logic             pcs_rxvalid,
    cbus_axis_if.master      m_axis,
    output logic             link_up,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] error_count
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic sym_bad, is_idle, is_sof, is_eof;
    logic sync_ok, lose_sync;

    assign sym_bad = pcs_rxdisperr | pcs_rxnotintable;
    assign is_idle = is_kchar(pcs_rxcharisk, pcs_rxdata, K_IDLE);
    assign is_sof  = is_kchar(pcs_rxcharisk, pcs_rxdata, K_SOF);
    assign is_eof  = is_kchar(pcs_rxcharisk, pcs_rxdata, K_EOF);

    cbus_rx_sync #(
        .SYNC_COMMAS (SYNC_COMMAS),
        .BAD_LIMIT   (BAD_LIMIT)
    ) u_sync (
        .rx_core_clk (rx_core_clk),
        .rx_reset    (rx_reset),
        .sym_valid   (pcs_rxvalid),
        .sym_bad     (sym_bad),
        .sym_is_idle (is_idle),
        .sync_ok     (sync_ok),
        .lose_sync   (lose_sync),
        .link_up     (link_up)
    );

    state_t           state_reg, state_next;
    logic [7:0]       hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] frame_count_reg, error_count_reg;
    logic             tvalid_reg, tlast_reg, tuser_reg;
    logic [7:0]       tdata_reg;

    logic       beat_valid, beat_last, beat_user;
    logic       abort, frame_inc;
    logic [1:0] err_inc;

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        len_next       = len_reg;
        beat_valid     = 1'b0;
        beat_last      = 1'b0;
        beat_user      = 1'b0;
        abort          = 1'b0;
        frame_inc      = 1'b0;
        err_inc        = 2'd0;
        if (pcs_rxvalid) begin
            case (state_reg)
                UNSYNC: begin
                    if (sync_ok) state_next = IDLE;
                end
                IDLE: begin
                    if (sym_bad) begin
                        err_inc = 2'd1;
                    end else if (is_sof) begin
                        state_next     = FRAME;
                        len_next       = '0;
                        hold_full_next = 1'b0;
                    end
                end
                FRAME: begin
                    if (sym_bad) begin
                        // Counted once as a bad symbol and once as an abort.
                        abort      = 1'b1;
                        err_inc    = 2'd2;
                        state_next = IDLE;
                    end else if (is_eof) begin
                        if (hold_full_reg) begin
                            beat_valid = 1'b1;
                            beat_last  = 1'b1;
                            frame_inc  = 1'b1;
                        end
                        hold_full_next = 1'b0;
                        state_next     = IDLE;
                    end else if (pcs_rxcharisk) begin
                        abort      = 1'b1;
                        err_inc    = 2'd1;
                        state_next = is_sof ? FRAME : IDLE;
                        len_next   = '0;
                    end else if (len_reg == LEN_W'(MAX_LEN)) begin
                        abort      = 1'b1;
                        err_inc    = 2'd1;
                        state_next = IDLE;
                    end else begin
                        beat_valid     = hold_full_reg;
                        hold_next      = pcs_rxdata;
                        hold_full_next = 1'b1;
                        len_next       = len_reg + 1'b1;
                    end
                    if (abort) begin
                        beat_valid     = hold_full_reg;
                        beat_last      = hold_full_reg;
                        beat_user      = hold_full_reg;
                        hold_full_next = 1'b0;
                    end
                end
                default: state_next = UNSYNC;
            endcase
            if (lose_sync) begin
                state_next = UNSYNC;
            end
        end
    end

    always_ff @(posedge rx_core_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state_reg       <= UNSYNC;
            hold_reg        <= '0;
            hold_full_reg   <= 1'b0;
            len_reg         <= '0;
            frame_count_reg <= '0;
            error_count_reg <= '0;
            tvalid_reg      <= 1'b0;
            tdata_reg       <= '0;
            tlast_reg       <= 1'b0;
            tuser_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_reg        <= hold_next;
            hold_full_reg   <= hold_full_next;
            len_reg         <= len_next;
            frame_count_reg <= frame_count_reg + CNT_W'(frame_inc);
            error_count_reg <= error_count_reg + CNT_W'(err_inc);
            tvalid_reg      <= beat_valid;
            tdata_reg       <= beat_valid ? hold_reg : 8'h00;
            tlast_reg       <= beat_last;
            tuser_reg       <= beat_user;
        end
    end

    assign m_axis.tvalid = tvalid_reg;
    assign m_axis.tdata  = tdata_reg;
    assign m_axis.tlast  = tlast_reg;
    assign m_axis.tuser  = tuser_reg;
    assign frame_count   = frame_count_reg;
    assign error_count   = error_count_reg;

endmodule

// File: doc/cbus_rx_deframer.md
Name: cbus_rx_deframer

Overview:
- Receive-side MAC deframer for the Cbus link; the counterpart of the TX framer that emits K-character-delimited frames into the 8b/10b PCS.
- Consumes decoded PCS symbols (data/charisk/disperr/notintable/valid) and tracks comma alignment.
- Strips SOF/EOF delimiters and emits payload bytes on an AXIS master with tlast and an error flag.
- Sits between the Cbus PHY RX output and the fabric m_axis consumer, in the rx_core_clk domain.

Parameters:
SYNC_COMMAS, 4, consecutive good K28.5 symbols required to declare link_up
BAD_LIMIT, 4, consecutive bad symbols (disperr or notintable) that drop link_up
MAX_LEN, 1024, maximum payload bytes per frame; a longer frame is aborted
CNT_W, 16, width of the frame and error counters

Ports:
rx_core_clk  in  1  core clock, 125 MHz
rx_reset  in  1  asynchronous, active-high reset
pcs_rxdata  in  8  decoded byte
pcs_rxcharisk  in  1  byte is a K character
pcs_rxdisperr  in  1  disparity error
pcs_rxnotintable  in  1  code not in 8b/10b table
pcs_rxvalid  in  1  symbol valid this cycle; symbols are ignored when low
m_axis_tdata  out  8  payload byte
m_axis_tvalid  out  1  one-cycle beat strobe; no tready, the consumer must always accept
m_axis_tlast  out  1  last byte of frame
m_axis_tuser  out  1  with tlast: frame aborted/errored
link_up  out  1  comma sync achieved
frame_count  out  CNT_W  good frames delivered, wraps
error_count  out  CNT_W  aborts plus bad symbols, wraps

Behaviour:
- Reset: one clock domain, rx_core_clk. rx_reset is asynchronous and active-high. During reset all outputs are 0, state is UNSYNC, the hold register is empty, and counters are 0.
- Accepted symbol: pcs_rxvalid=1.
  - bad = disperr | notintable.
  - Delimiters: IDLE=K28.5 (0xBC), SOF=K27.7 (0xFB), EOF=K29.7 (0xFD).
- Sync tracking: on every accepted symbol, bad increments the bad-run counter and good clears it.
  - Bad-run reaching BAD_LIMIT in any state: abort any open frame, go to UNSYNC, link_up<=0.
- UNSYNC:
  - Count consecutive good IDLE symbols; any other accepted symbol clears the count.
  - Count reaching SYNC_COMMAS: go to IDLE, link_up<=1.
  - Bad symbols in UNSYNC do not increment error_count.
- IDLE:
  - SOF: go to FRAME, len<=0, hold empty.
  - Bad symbol: error_count++.
  - IDLE, EOF, data or other K: ignored.
- FRAME, on a data byte:
  - If len==MAX_LEN: abort, then go to IDLE.
  - Otherwise: if hold is full, emit the held byte (tlast=0, tuser=0); load the new byte into hold; len++.
- FRAME, on EOF:
  - Hold full: emit the held byte with tlast=1, tuser=0; frame_count++.
  - Hold empty (zero-length frame): nothing emitted and no counters change.
  - Then go to IDLE.
- FRAME, abort conditions:
  - A bad symbol, or any K other than EOF, aborts the frame.
  - Abort with hold full: emit the held byte with tlast=1, tuser=1.
  - Abort with hold empty: nothing emitted.
  - Every abort does error_count++; a bad symbol also counts as one error, so a bad symbol that aborts a frame adds 2 in total.
  - Next state: SOF goes to FRAME (new frame, len<=0); all other aborts go to IDLE.
- Output registers:
  - A beat appears exactly one cycle after the accepted symbol that released it.
  - A payload byte therefore lags its own arrival by one accepted symbol plus one cycle.
  - tvalid is low on every cycle with no emission; tlast and tuser are 0 whenever tvalid is 0.
- pcs_rxvalid=0 gaps: state, hold and bad-run counter are frozen; no output.
- Reset mid-frame: held byte discarded, no tlast emitted.

Decomposition:
- Package cbus_pkg:
  - K_IDLE, K_SOF and K_EOF byte constants.
  - State enum {UNSYNC, IDLE, FRAME}.
  - Shared with the TX framer.
- One sub-module, cbus_rx_sync:
  - Owns the comma counter, bad-run counter and link_up.
  - Outputs sync_ok and a lose_sync pulse to the deframer FSM.
- The FSM, hold register, length counter and status counters stay in cbus_rx_deframer.

Test Plan:
- Sync: 3 good IDLE then a data byte, then 4 IDLE -> link_up stays 0 until the 4th IDLE of the second run, then rises.
- Normal frame: SOF, 0x11 0x22 0x33, EOF, with rxvalid gaps inserted -> 3 beats 0x11/0x22/0x33; tlast only on 0x33; tuser=0; frame_count=1; each beat one cycle after the next accepted symbol.
- Empty frame: SOF, EOF -> no beats; frame_count and error_count unchanged.
- Mid-frame error: SOF, 0xA0, 0xA1, then a symbol with disperr=1 -> beat 0xA0 (tlast=0), then 0xA1 with tlast=1, tuser=1; error_count=2; state IDLE.
- SOF restart and length limit, MAX_LEN=4:
  - SOF, 5 data bytes -> bytes 1-3 emitted, byte 4 emitted with tlast=1, tuser=1; fifth byte dropped.
  - SOF, 0x55, SOF, 0x66, EOF -> 0x55 with tlast=1, tuser=1, then 0x66 with tlast=1, tuser=0.
- Loss of sync: 4 consecutive notintable symbols mid-frame -> abort beat, link_up<=0, UNSYNC; assert rx_reset mid-frame -> all outputs 0 immediately, no beat.
